// File: rtl/alu_operand_loader_if.sv
// Board-input / ALU-operand bundle between the operand loader and the ALU harness.
interface alu_operand_loader_if;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic [31:0] portA;
  logic [31:0] portB;
  logic [3:0]  ALUOP;
  logic        op_valid;
  logic [1:0]  load_state;

  modport master (
    input  KEY, SW,
    output portA, portB, ALUOP, op_valid, load_state
  );

  modport slave (
    output KEY, SW,
    input  portA, portB, ALUOP, op_valid, load_state
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Input conditioning (sync + debounce) and A/B/opcode load sequencer feeding the ALU
// from registers so it never sees live switch/key levels.

module alu_operand_loader_db #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic key_sync,
  output logic key_db,
  output logic press
);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] cnt;

  // The strobe is raised on the same edge the debounced level falls, so the
  // sequencer acts one edge later: 2 sync + DB_CYCLES + 1 in total.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_db <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync != key_db) begin
        if (cnt == DB_LAST) begin
          key_db <= key_sync;
          cnt    <= '0;
          press  <= key_db & ~key_sync;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module alu_operand_loader #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic                        CLOCK_50,
  input  logic                        RST,
  alu_operand_loader_if.master        bus
);
  localparam int NUM_KEYS = 4;

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] SEL_OP = 2'd2;
  localparam logic [1:0] RUN    = 2'd3;

  logic [NUM_KEYS-1:0] key_s1, key_s2, key_db, press;
  logic [17:0]         sw_s1, sw_s2;
  logic [31:0]         sext;
  logic [1:0]          state;
  logic                sw_unused;

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= bus.KEY;
      key_s2 <= key_s1;
      sw_s1  <= bus.SW;
      sw_s2  <= sw_s1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
    alu_operand_loader_db #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
    ) u_db (
      .clk      (CLOCK_50),
      .rst      (RST),
      .key_sync (key_s2[i]),
      .key_db   (key_db[i]),
      .press    (press[i])
    );
  end

  assign sext      = {{16{sw_s2[16]}}, sw_s2[15:0]};
  assign sw_unused = sw_s2[17];

  // One action per cycle: clear > back > re-fire > step.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      bus.portA    <= '0;
      bus.portB    <= '0;
      bus.ALUOP    <= '0;
      bus.op_valid <= 1'b0;
      state        <= LOAD_A;
    end else begin
      bus.op_valid <= 1'b0;
      if (press[3]) begin
        bus.portA <= '0;
        bus.portB <= '0;
        bus.ALUOP <= '0;
        state     <= LOAD_A;
      end else if (press[1]) begin
        if (state != LOAD_A) state <= state - 2'd1;
      end else if (press[2]) begin
        if (state == RUN) bus.op_valid <= 1'b1;
      end else if (press[0]) begin
        case (state)
          LOAD_A: begin
            bus.portA <= sext;
            state     <= LOAD_B;
          end
          LOAD_B: begin
            bus.portB <= sext;
            state     <= SEL_OP;
          end
          SEL_OP: begin
            bus.ALUOP    <= sw_s2[3:0];
            bus.op_valid <= 1'b1;
            state        <= RUN;
          end
          default: state <= LOAD_A;
        endcase
      end
    end
  end

  assign bus.load_state = state;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader; op_valid events are checked by a scoreboard monitor.
module tb_alu_operand_loader;
  typedef struct packed {
    logic [3:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic CLOCK_50 = 1'b0;
  logic RST;
  alu_operand_loader_if bus ();

  alu_operand_loader #(.DB_CYCLES(4), .DB_W(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  op_t  exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  logic prev_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic press_key(input logic [3:0] mask);
    bus.KEY = ~mask;
    tick(10);
    bus.KEY = 4'hF;
    tick(10);
  endtask

  // Scoreboard monitor: every op_valid pulse must match the next expected op.
  always @(negedge CLOCK_50) begin
    if (RST === 1'b0 && bus.op_valid === 1'b1) begin
      n_total++;
      if (prev_vld) $display("FAIL op_valid_width: got two consecutive high cycles, required one");
      else n_pass++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL op_valid_unexpected: got pulse aluop=%h a=%h b=%h, required none",
                 bus.ALUOP, bus.portA, bus.portB);
      end else begin
        op_t e;
        e = exp_q.pop_front();
        if (bus.ALUOP === e.aluop && bus.portA === e.a && bus.portB === e.b) n_pass++;
        else $display("FAIL op_commit: got aluop=%h a=%h b=%h, required aluop=%h a=%h b=%h",
                      bus.ALUOP, bus.portA, bus.portB, e.aluop, e.a, e.b);
      end
    end
    prev_vld = (bus.op_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.KEY = 4'hF;
    bus.SW  = '0;
    RST     = 1'b1;
    tick(2);
    chk("rst_portA", bus.portA, 32'h0);
    chk("rst_portB", bus.portB, 32'h0);
    chk("rst_ALUOP", {28'h0, bus.ALUOP}, 32'h0);
    chk("rst_op_valid", {31'h0, bus.op_valid}, 32'h0);
    chk("rst_state", {30'h0, bus.load_state}, 32'h0);
    RST = 1'b0;

    // 1: exact capture latency of operand A
    bus.SW = 18'h0_1234;
    tick(3);
    bus.KEY = 4'hE;
    tick(6);
    chk("lat_portA_edge6", bus.portA, 32'h0);
    tick(1);
    chk("lat_portA_edge7", bus.portA, 32'h0000_1234);
    chk("lat_state", {30'h0, bus.load_state}, 32'd1);
    tick(3);
    bus.KEY = 4'hF;
    tick(10);

    // 2: sign extension and opcode
    bus.SW = 18'h1_8000;
    press_key(4'b0001);
    chk("sext_portB", bus.portB, 32'hFFFF_8000);
    chk("sext_state", {30'h0, bus.load_state}, 32'd2);
    bus.SW = 18'h0_0003;
    exp_q.push_back('{aluop: 4'h3, a: 32'h0000_1234, b: 32'hFFFF_8000});
    press_key(4'b0001);
    chk("op_ALUOP", {28'h0, bus.ALUOP}, 32'h3);
    chk("op_state", {30'h0, bus.load_state}, 32'd3);

    // 3: glitches shorter than DB_CYCLES
    for (int i = 0; i < 5; i++) begin
      bus.KEY = 4'hE;
      tick(3);
      bus.KEY = 4'hF;
      tick(3);
    end
    tick(10);
    chk("glitch_state", {30'h0, bus.load_state}, 32'd3);
    chk("glitch_portA", bus.portA, 32'h0000_1234);

    // 4: clear beats step in the same cycle
    press_key(4'b0001);
    chk("run_step_state", {30'h0, bus.load_state}, 32'd0);
    chk("run_step_hold", bus.portA, 32'h0000_1234);
    bus.SW = 18'h0_0005;
    press_key(4'b0001);
    press_key(4'b0001);
    chk("pri_pre_portA", bus.portA, 32'h5);
    chk("pri_pre_state", {30'h0, bus.load_state}, 32'd2);
    press_key(4'b1001);
    chk("pri_portA", bus.portA, 32'h0);
    chk("pri_portB", bus.portB, 32'h0);
    chk("pri_ALUOP", {28'h0, bus.ALUOP}, 32'h0);
    chk("pri_state", {30'h0, bus.load_state}, 32'd0);

    // 5: re-fire and back
    bus.SW = 18'h0_0007;
    press_key(4'b0001);
    bus.SW = 18'h0_0002;
    press_key(4'b0001);
    bus.SW = 18'h0_0009;
    exp_q.push_back('{aluop: 4'h9, a: 32'h7, b: 32'h2});
    press_key(4'b0001);
    exp_q.push_back('{aluop: 4'h9, a: 32'h7, b: 32'h2});
    press_key(4'b0100);
    chk("refire_state", {30'h0, bus.load_state}, 32'd3);
    press_key(4'b0010);
    chk("back_state", {30'h0, bus.load_state}, 32'd2);
    chk("back_ALUOP", {28'h0, bus.ALUOP}, 32'h9);
    press_key(4'b0100);
    chk("refire_selop_state", {30'h0, bus.load_state}, 32'd2);

    // 6: reset mid-debounce restarts the count
    bus.SW = 18'h0_0042;
    tick(3);
    bus.KEY = 4'hE;
    tick(2);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(6);
    chk("rstdb_portA_early", bus.portA, 32'h0);
    chk("rstdb_state_early", {30'h0, bus.load_state}, 32'd0);
    tick(1);
    chk("rstdb_portA", bus.portA, 32'h42);
    chk("rstdb_state", {30'h0, bus.load_state}, 32'd1);
    bus.KEY = 4'hF;
    tick(10);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
